decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered main-decode stage between IF/ID and ID/EX. Takes {pc, instr}, emits the packed control word, extension/memory
//  attributes, reserved-instruction flag and branch-delay-slot tag. Adds valid/ready handshake, optional skid entry,
//  flush, and decode classes gated by parameters.
// PARAMETERS
//  PC_W    32  width of pc pass-through
//  SKID    1   1: two-entry buffer with registered in_ready; 0: one entry, in_ready = !out_valid | out_ready
//  EN_MEM  1   0: loads/stores decode as reserved
//  EN_BJ   1   0: branches/jumps (incl. JR/JALR/REGIMM) decode as reserved
// PORTS
//  clk          in   1     clock, rising edge
//  resetn       in   1     asynchronous active-low reset
//  flush        in   1     discard all held entries and clear delay-slot tracking
//  in_valid     in   1     upstream instruction valid
//  in_ready     out  1     stage can accept
//  in_pc        in   PC_W  pc of in_instr
//  in_instr     in   32    MIPS instruction word
//  out_valid    out  1     decoded entry valid
//  out_ready    in   1     downstream accepts
//  out_pc       out  PC_W  pc of decoded entry
//  out_ctrl     out  9     {jump,branch,alu_src,mem_read,mem_write,mem_to_reg,reg_write,reg_dst[1:0]}; reg_dst 00 rt, 01 rd, 10 $ra
//  out_sign_ext out  1     0 for ANDI/ORI/XORI/LUI, else 1
//  out_mem_size out  2     00 byte, 01 half, 10 word; 00 when not memory
//  out_mem_uns  out  1     1 for LBU/LHU
//  out_ri       out  1     reserved/disabled instruction; out_ctrl forced 0
//  out_ds       out  1     entry is in a branch delay slot
// BEHAVIOUR
//  - Reset (async, resetn=0): out_valid=0, all out_* data=0, ds_pending=0, skid empty, in_ready=1. No transfer while resetn=0.
//  - Decode is combinational on in_instr; captured on accept (in_valid&in_ready). Latency: one cycle accept->out_valid.
//  - Decode table (ctrl hex): R-type AND/OR/XOR/NOR/ADD/ADDU/SUB/SUBU/SLT/SLTU/SLL/SRL/SRA = 0x005; JR = 0x100;
//    JALR = 0x105; ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU = 0x044; BEQ/BNE/BLEZ/BGTZ, REGIMM BLTZ/BGEZ = 0x080;
//    BLTZAL/BGEZAL = 0x086; J = 0x100; JAL = 0x106; LB/LH/LW/LBU/LHU = 0x06C; SB/SH/SW = 0x050.
//    Any other op, funct, or REGIMM rt code -> out_ri=1, ctrl=0, mem_size=00, mem_uns=0.
//  - Delay slot: ds_pending set when accepted instr has jump|branch; next accepted instr gets out_ds=1 and clears
//    ds_pending (unless it is itself a branch/jump -> stays set). ri entries never set ds_pending.
//  - Output hold: while out_valid & !out_ready, all out_* stable.
//  - SKID=1: main entry + skid entry. Accept when main full and blocked -> goes to skid; in_ready = !skid_valid (registered).
//    On out_ready, skid moves to main same edge; order preserved.
//  - SKID=0: in_ready = !out_valid | out_ready; accept and drain in same cycle allowed (back-to-back, full rate).
//  - flush (synchronous, highest priority): next edge out_valid=0, skid empty, ds_pending=0, same-cycle input dropped.
//    in_ready=1 following cycle.
//  - No combinational path in_valid->out_valid; out_ready->in_ready only when SKID=0.
//  - Mid-operation reset: entries discarded immediately, outputs at reset values.
// TESTING
//  1. ORI 0x342100FF, out_ready=1 -> next cycle out_valid=1, ctrl=0x044, sign_ext=0, ri=0, ds=0.
//  2. BEQ 0x10220003 then ADDU 0x00221821 back-to-back -> ctrl 0x080 ds=0, then ctrl 0x005 ds=1.
//  3. LHU 0x94220002 / SB 0xA0220001 -> ctrl 0x06C size=01 uns=1 / ctrl 0x050 size=00 uns=0; with EN_MEM=0 -> ri=1, ctrl=0.
//  4. SKID=1, out_ready=0, feed 3 instrs -> first two accepted, in_ready=0; release -> drain in order, no loss/dup.
//  5. Held entry + skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; next BEQ successor gets ds=0.
//  6. op 0x3F / REGIMM rt=0x05 / JAL 0x0C000010 -> ri=1 ctrl=0 / ri=1 / ctrl=0x106; resetn=0 mid-stall -> out_valid=0 at once.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// Main-decode pipeline stage between IF/ID and ID/EX: decodes a MIPS word into
// a packed control word plus memory/extension attributes, tags delay slots and
// holds results behind a valid/ready handshake with an optional skid entry.

package decode_ctrl_pipe_pkg;

   localparam int unsigned CTRL_W       = 9;
   localparam int unsigned CTRL_JUMP    = 8;
   localparam int unsigned CTRL_BRANCH  = 7;

   // ctrl = {jump,branch,alu_src,mem_read,mem_write,mem_to_reg,reg_write,reg_dst[1:0]}
   localparam logic [CTRL_W-1:0] CTRL_RTYPE = 9'h005;
   localparam logic [CTRL_W-1:0] CTRL_JR    = 9'h100;
   localparam logic [CTRL_W-1:0] CTRL_JALR  = 9'h105;
   localparam logic [CTRL_W-1:0] CTRL_IMM   = 9'h044;
   localparam logic [CTRL_W-1:0] CTRL_BR    = 9'h080;
   localparam logic [CTRL_W-1:0] CTRL_BRAL  = 9'h086;
   localparam logic [CTRL_W-1:0] CTRL_J     = 9'h100;
   localparam logic [CTRL_W-1:0] CTRL_JAL   = 9'h106;
   localparam logic [CTRL_W-1:0] CTRL_LOAD  = 9'h06C;
   localparam logic [CTRL_W-1:0] CTRL_STORE = 9'h050;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              sign_ext;
      logic [1:0]        mem_size;
      logic              mem_uns;
      logic              ri;
      logic              ds;
   } dec_attr_t;

endpackage

module decode_ctrl_pipe
   import decode_ctrl_pipe_pkg::*;
#(
   parameter int unsigned PC_W   = 32,
   parameter bit          SKID   = 1'b1,
   parameter bit          EN_MEM = 1'b1,
   parameter bit          EN_BJ  = 1'b1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [8:0]      out_ctrl,
   output logic            out_sign_ext,
   output logic [1:0]      out_mem_size,
   output logic            out_mem_uns,
   output logic            out_ri,
   output logic            out_ds
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   logic       unused_instr_bits;

   dec_attr_t  dec_c;
   logic       legal_c;
   logic       is_mem_c;
   logic       is_bj_c;

   logic            main_valid;
   logic [PC_W-1:0] main_pc;
   dec_attr_t       main_attr;
   logic            skid_valid;
   logic [PC_W-1:0] skid_pc;
   dec_attr_t       skid_attr;
   logic            ds_pending;

   logic accept_c;
   logic main_free_c;

   assign op    = in_instr[31:26];
   assign rt    = in_instr[20:16];
   assign funct = in_instr[5:0];
   assign unused_instr_bits = ^{in_instr[25:21], in_instr[15:6]};

   // Skid variant: ready depends only on a flop; single-entry variant passes out_ready through.
   assign in_ready    = SKID ? ~skid_valid : (~main_valid | out_ready);
   assign accept_c    = in_valid & in_ready;
   assign main_free_c = ~main_valid | out_ready;

   // Combinational main decode of the incoming word, with class gating.
   always_comb begin
      dec_c          = '0;
      dec_c.sign_ext = 1'b1;
      legal_c        = 1'b1;
      is_mem_c       = 1'b0;
      is_bj_c        = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00, 6'h02, 6'h03,
               6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B: dec_c.ctrl = CTRL_RTYPE;
               6'h08: begin dec_c.ctrl = CTRL_JR;   is_bj_c = 1'b1; end
               6'h09: begin dec_c.ctrl = CTRL_JALR; is_bj_c = 1'b1; end
               default: legal_c = 1'b0;
            endcase
         end
         6'h01: begin
            is_bj_c = 1'b1;
            case (rt)
               5'h00, 5'h01: dec_c.ctrl = CTRL_BR;
               5'h10, 5'h11: dec_c.ctrl = CTRL_BRAL;
               default:      legal_c = 1'b0;
            endcase
         end
         6'h02: begin dec_c.ctrl = CTRL_J;   is_bj_c = 1'b1; end
         6'h03: begin dec_c.ctrl = CTRL_JAL; is_bj_c = 1'b1; end
         6'h04, 6'h05, 6'h06, 6'h07: begin dec_c.ctrl = CTRL_BR; is_bj_c = 1'b1; end
         6'h08, 6'h09, 6'h0A, 6'h0B: dec_c.ctrl = CTRL_IMM;
         6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dec_c.ctrl     = CTRL_IMM;
            dec_c.sign_ext = 1'b0;
         end
         6'h20: begin dec_c.ctrl = CTRL_LOAD;  dec_c.mem_size = SIZE_BYTE; is_mem_c = 1'b1; end
         6'h21: begin dec_c.ctrl = CTRL_LOAD;  dec_c.mem_size = SIZE_HALF; is_mem_c = 1'b1; end
         6'h23: begin dec_c.ctrl = CTRL_LOAD;  dec_c.mem_size = SIZE_WORD; is_mem_c = 1'b1; end
         6'h24: begin
            dec_c.ctrl = CTRL_LOAD; dec_c.mem_size = SIZE_BYTE; dec_c.mem_uns = 1'b1; is_mem_c = 1'b1;
         end
         6'h25: begin
            dec_c.ctrl = CTRL_LOAD; dec_c.mem_size = SIZE_HALF; dec_c.mem_uns = 1'b1; is_mem_c = 1'b1;
         end
         6'h28: begin dec_c.ctrl = CTRL_STORE; dec_c.mem_size = SIZE_BYTE; is_mem_c = 1'b1; end
         6'h29: begin dec_c.ctrl = CTRL_STORE; dec_c.mem_size = SIZE_HALF; is_mem_c = 1'b1; end
         6'h2B: begin dec_c.ctrl = CTRL_STORE; dec_c.mem_size = SIZE_WORD; is_mem_c = 1'b1; end
         default: legal_c = 1'b0;
      endcase
      if (!legal_c || (is_mem_c && !EN_MEM) || (is_bj_c && !EN_BJ)) begin
         dec_c.ctrl     = '0;
         dec_c.mem_size = 2'b00;
         dec_c.mem_uns  = 1'b0;
         dec_c.ri       = 1'b1;
      end
      dec_c.ds = ds_pending;
   end

   // Delay-slot tracking: set by an accepted jump/branch, consumed by the next accept.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_pending <= 1'b0;
      end else if (flush) begin
         ds_pending <= 1'b0;
      end else if (accept_c) begin
         ds_pending <= dec_c.ctrl[CTRL_JUMP] | dec_c.ctrl[CTRL_BRANCH];
      end
   end

   // Main/skid storage: main refills from skid first so order is preserved.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_attr  <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_attr  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free_c) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_pc    <= skid_pc;
            main_attr  <= skid_attr;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept_c;
            if (accept_c) begin
               main_pc   <= in_pc;
               main_attr <= dec_c;
            end
         end
      end else if (accept_c && SKID) begin
         skid_valid <= 1'b1;
         skid_pc    <= in_pc;
         skid_attr  <= dec_c;
      end
   end

   assign out_valid    = main_valid;
   assign out_pc       = main_pc;
   assign out_ctrl     = main_attr.ctrl;
   assign out_sign_ext = main_attr.sign_ext;
   assign out_mem_size = main_attr.mem_size;
   assign out_mem_uns  = main_attr.mem_uns;
   assign out_ri       = main_attr.ri;
   assign out_ds       = main_attr.ds;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: a full-featured skid instance and a single-entry
// instance with memory and branch/jump classes disabled, checked via scoreboards.

module tb_decode_ctrl_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [8:0]  ctrl;
      logic        se;
      logic [1:0]  sz;
      logic        u;
      logic        ri;
      logic        ds;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [8:0]  out_ctrl;
   logic        out_sign_ext;
   logic [1:0]  out_mem_size;
   logic        out_mem_uns;
   logic        out_ri;
   logic        out_ds;

   logic        b_en;
   logic        b_in_valid;
   logic        b_in_ready;
   logic        b_out_valid;
   logic [31:0] b_out_pc;
   logic [8:0]  b_out_ctrl;
   logic        b_out_sign_ext;
   logic [1:0]  b_out_mem_size;
   logic        b_out_mem_uns;
   logic        b_out_ri;
   logic        b_out_ds;

   int   total = 0;
   int   bad   = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic ds_a;
   logic ds_b;
   logic a_hold;
   exp_t a_prev;
   exp_t a_obs;
   exp_t b_obs;

   assign b_in_valid = in_valid & b_en;
   assign a_obs = {out_pc, out_ctrl, out_sign_ext, out_mem_size, out_mem_uns, out_ri, out_ds};
   assign b_obs = {b_out_pc, b_out_ctrl, b_out_sign_ext, b_out_mem_size, b_out_mem_uns, b_out_ri, b_out_ds};

   decode_ctrl_pipe #(.PC_W(32), .SKID(1'b1), .EN_MEM(1'b1), .EN_BJ(1'b1)) u_dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
      .out_sign_ext(out_sign_ext), .out_mem_size(out_mem_size), .out_mem_uns(out_mem_uns),
      .out_ri(out_ri), .out_ds(out_ds)
   );

   decode_ctrl_pipe #(.PC_W(32), .SKID(1'b0), .EN_MEM(1'b0), .EN_BJ(1'b0)) u_dut_b (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_ctrl(b_out_ctrl),
      .out_sign_ext(b_out_sign_ext), .out_mem_size(b_out_mem_size), .out_mem_uns(b_out_mem_uns),
      .out_ri(b_out_ri), .out_ds(b_out_ds)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard and output-hold monitor for the skid instance.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && out_valid) begin
         if (a_hold) begin
            total++;
            if (a_obs !== a_prev) begin
               bad++;
               $display("FAIL hold_a: got %h want %h", a_obs, a_prev);
            end
         end
         if (out_ready) begin
            total++;
            if (qa.size() == 0) begin
               bad++;
               $display("FAIL out_a: got %h want nothing", a_obs);
            end else begin
               e = qa.pop_front();
               if (a_obs !== e) begin
                  bad++;
                  $display("FAIL out_a: got %h want %h", a_obs, e);
               end
            end
         end
         a_hold = !out_ready;
         a_prev = a_obs;
      end else begin
         a_hold = 1'b0;
      end
   end

   // Scoreboard for the single-entry, class-disabled instance.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && b_out_valid && out_ready) begin
         total++;
         if (qb.size() == 0) begin
            bad++;
            $display("FAIL out_b: got %h want nothing", b_obs);
         end else begin
            e = qb.pop_front();
            if (b_obs !== e) begin
               bad++;
               $display("FAIL out_b: got %h want %h", b_obs, e);
            end
         end
      end
   end

   // Present one instruction, wait (bounded) for acceptance, push expectations.
   task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic [8:0] ctrl,
                       input logic se, input logic [1:0] sz, input logic u, input logic ri, input int cls);
      exp_t e;
      int   n;
      logic ok;
      e = {pc, ctrl, se, sz, u, ri, ds_a};
      qa.push_back(e);
      ds_a = ctrl[8] | ctrl[7];
      if (b_en) begin
         if (cls != 0) e = {pc, 9'h000, se, 2'b00, 1'b0, 1'b1, ds_b};
         else          e.ds = ds_b;
         qb.push_back(e);
         ds_b = e.ctrl[8] | e.ctrl[7];
      end
      in_pc    = pc;
      in_instr = instr;
      in_valid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         @(negedge clk);
         ok = in_ready;
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1 for pc %h", pc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain: got pending a=%0d b=%0d want 0", qa.size(), qb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (a_obs !== '0)       begin bad++; $display("FAIL rst_data: got %h want 0", a_obs); end
      total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_b: got valid=%b ready=%b want 0/1", b_out_valid, b_in_ready);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      out_ready = 1'b1;
   endtask

   task automatic test_ori();
      send(32'h0000_0100, 32'h3421_00FF, 9'h044, 1'b0, 2'b00, 1'b0, 1'b0, 0);
      total++;
      if (out_valid !== 1'b1 || out_ctrl !== 9'h044 || out_sign_ext !== 1'b0) begin
         bad++; $display("FAIL ori_latency: got v=%b ctrl=%h se=%b want 1/044/0", out_valid, out_ctrl, out_sign_ext);
      end
      total++;
      if (b_out_valid !== 1'b1) begin bad++; $display("FAIL ori_latency_b: got %b want 1", b_out_valid); end
      drain();
   endtask

   task automatic test_back_to_back();
      send(32'h0000_0104, 32'h1022_0003, 9'h080, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      send(32'h0000_0108, 32'h0022_1821, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      send(32'h0000_010C, 32'h0000_0009, 9'h105, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      send(32'h0000_0110, 32'h0022_1824, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      drain();
   endtask

   task automatic test_mem();
      send(32'h0000_0200, 32'h9422_0002, 9'h06C, 1'b1, 2'b01, 1'b1, 1'b0, 1);
      send(32'h0000_0204, 32'hA022_0001, 9'h050, 1'b1, 2'b00, 1'b0, 1'b0, 1);
      send(32'h0000_0208, 32'h8C22_0004, 9'h06C, 1'b1, 2'b10, 1'b0, 1'b0, 1);
      send(32'h0000_020C, 32'h9022_0000, 9'h06C, 1'b1, 2'b00, 1'b1, 1'b0, 1);
      drain();
   endtask

   task automatic test_reserved();
      send(32'h0000_0220, 32'hFC00_0000, 9'h000, 1'b1, 2'b00, 1'b0, 1'b1, 0);
      send(32'h0000_0224, 32'h0405_0000, 9'h000, 1'b1, 2'b00, 1'b0, 1'b1, 0);
      send(32'h0000_0228, 32'h0C00_0010, 9'h106, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      send(32'h0000_022C, 32'h0022_1821, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      send(32'h0000_0230, 32'h0411_0002, 9'h086, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      send(32'h0000_0234, 32'h0000_003F, 9'h000, 1'b1, 2'b00, 1'b0, 1'b1, 0);
      send(32'h0000_0238, 32'h3C01_1234, 9'h044, 1'b0, 2'b00, 1'b0, 1'b0, 0);
      drain();
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      send(32'h0000_0300, 32'h2001_0005, 9'h044, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      send(32'h0000_0304, 32'h2801_0003, 9'h044, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      in_pc    = 32'h0000_0308;
      in_instr = 32'h3801_0001;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL skid_full: got ready=%b valid=%b want 0/1", in_ready, out_valid);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h0000_0308, 32'h3801_0001, 9'h044, 1'b0, 2'b00, 1'b0, 1'b0, 0);
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(32'h0000_0400, 32'h0022_1821, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      send(32'h0000_0404, 32'h1022_0003, 9'h080, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      in_pc    = 32'h0000_0408;
      in_instr = 32'h3421_00FF;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      qa.delete();
      ds_a = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL flush: got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h0000_040C, 32'h0022_1821, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(32'h0000_0500, 32'h3421_00FF, 9'h044, 1'b0, 2'b00, 1'b0, 1'b0, 0);
      #3;
      resetn = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_obs !== '0) begin
         bad++; $display("FAIL reset_mid: got valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, a_obs);
      end
      qa.delete();
      ds_a = 1'b0;
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      out_ready = 1'b1;
      send(32'h0000_0504, 32'h0C00_0010, 9'h106, 1'b1, 2'b00, 1'b0, 1'b0, 2);
      send(32'h0000_0508, 32'h0022_1821, 9'h005, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      drain();
   endtask

   initial begin
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      b_en      = 1'b1;
      ds_a      = 1'b0;
      ds_b      = 1'b0;
      a_hold    = 1'b0;
      a_prev    = '0;
      test_reset();
      test_ori();
      test_back_to_back();
      test_mem();
      test_reserved();
      b_en = 1'b0;
      test_skid();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
